// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: DMType codes, FSM states and
// request classification helpers.
package lsu_pkg;

    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_HU = 3'b010;
    localparam logic [2:0] DM_B  = 3'b011;
    localparam logic [2:0] DM_BU = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Stores have no unsigned variants, so only W/H/B are legal for them.
    function automatic logic dm_legal(input logic we, input logic [2:0] dmtype);
        if (we)
            return (dmtype == DM_W) || (dmtype == DM_H) || (dmtype == DM_B);
        else
            return (dmtype <= DM_BU);
    endfunction

    function automatic logic dm_misaligned(input logic [2:0] dmtype, input logic [1:0] off);
        return (((dmtype == DM_H) || (dmtype == DM_HU)) && (off == 2'b11)) ||
               ((dmtype == DM_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and write data for both beats,
// and the merged, extended load result.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  dmtype,
    input  logic        split,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata0,
    input  logic [31:0] rdata1,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] load_data
);

    logic [3:0]  size_mask;
    logic [7:0]  be_wide;
    logic [4:0]  sh0;
    logic [5:0]  sh1;
    logic [31:0] merged;

    always_comb begin
        size_mask = 4'b0001;
        case (dmtype)
            DM_W:         size_mask = 4'b1111;
            DM_H, DM_HU:  size_mask = 4'b0011;
            default:      size_mask = 4'b0001;
        endcase
    end

    // The upper nibble holds the enables that spill into the next word.
    assign be_wide = {4'b0000, size_mask} << off;
    assign be0     = be_wide[3:0];
    assign be1     = be_wide[7:4];

    assign sh0 = {off, 3'b000};
    assign sh1 = 6'd32 - {1'b0, off, 3'b000};

    assign wdata0 = wdata << sh0;
    assign wdata1 = wdata >> sh1;

    assign merged = (rdata0 >> sh0) | (split ? (rdata1 << sh1) : 32'h0);

    always_comb begin
        load_data = merged;
        case (dmtype)
            DM_H:    load_data = {{16{merged[15]}}, merged[15:0]};
            DM_HU:   load_data = {16'h0000, merged[15:0]};
            DM_B:    load_data = {{24{merged[7]}}, merged[7:0]};
            DM_BU:   load_data = {24'h000000, merged[7:0]};
            default: load_data = merged;
        endcase
    end

endmodule

// File: rtl/lsu_dm.sv
// Load/store unit: accepts one core access, runs one or two word beats on the
// data-memory bus and returns a registered one-cycle response.
module lsu_dm
    import lsu_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_dmtype,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_reg, state_next;
    logic [31:0] addr_reg;
    logic [2:0]  dmtype_reg;
    logic        we_reg;
    logic [31:0] wdata_reg;
    logic        split_reg;
    logic [31:0] rdata0_reg;
    logic [31:0] resp_rdata_reg;
    logic        resp_err_reg;

    logic        accept;
    logic        req_mis;
    logic        req_illegal;
    logic [3:0]  be0, be1;
    logic [31:0] wdata0, wdata1, load_data;
    logic [31:0] align_rdata0;
    logic [31:0] beat0_addr;

    assign req_mis     = dm_misaligned(req_dmtype, req_addr[1:0]);
    assign req_illegal = !dm_legal(req_we, req_dmtype) || (req_mis && !SPLIT_MISALIGNED);
    assign accept      = req_valid && req_ready;

    // Beat 1 merges the captured first word with the word on the bus now.
    assign align_rdata0 = (state_reg == BEAT1) ? rdata0_reg : mem_rdata;

    lsu_align u_align (
        .off       (addr_reg[1:0]),
        .dmtype    (dmtype_reg),
        .split     (split_reg),
        .wdata     (wdata_reg),
        .rdata0    (align_rdata0),
        .rdata1    (mem_rdata),
        .be0       (be0),
        .be1       (be1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .load_data (load_data)
    );

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = !rst;
                if (accept)
                    state_next = req_illegal ? RESP : BEAT0;
            end
            BEAT0: begin
                mem_req = 1'b1;
                if (mem_ack)
                    state_next = split_reg ? BEAT1 : RESP;
            end
            BEAT1: begin
                mem_req = 1'b1;
                if (mem_ack)
                    state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            addr_reg       <= 32'h0;
            dmtype_reg     <= 3'b000;
            we_reg         <= 1'b0;
            wdata_reg      <= 32'h0;
            split_reg      <= 1'b0;
            rdata0_reg     <= 32'h0;
            resp_rdata_reg <= 32'h0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg     <= req_addr;
                        dmtype_reg   <= req_dmtype;
                        we_reg       <= req_we;
                        wdata_reg    <= req_wdata;
                        split_reg    <= req_mis && SPLIT_MISALIGNED;
                        resp_err_reg <= req_illegal;
                    end
                end
                BEAT0: begin
                    if (mem_ack) begin
                        rdata0_reg <= mem_rdata;
                        if (!split_reg)
                            resp_rdata_reg <= we_reg ? 32'h0 : load_data;
                    end
                end
                BEAT1: begin
                    if (mem_ack)
                        resp_rdata_reg <= we_reg ? 32'h0 : load_data;
                end
                RESP: begin
                    resp_rdata_reg <= 32'h0;
                    resp_err_reg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign beat0_addr = {addr_reg[31:2], 2'b00};
    assign mem_we     = mem_req && we_reg;
    assign mem_addr   = (state_reg == BEAT1) ? (beat0_addr + 32'd4) : beat0_addr;
    assign mem_be     = !mem_req ? 4'b0000 : ((state_reg == BEAT1) ? be1 : be0);
    assign mem_wdata  = (state_reg == BEAT1) ? wdata1 : wdata0;
    assign resp_rdata = resp_rdata_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_lsu_dm.sv
// Directed bench for lsu_dm with an expected-response queue; bus beats are
// checked against hand-derived addresses, enables and lane data.
module tb_lsu_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [2:0]  req_dmtype;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    logic        req_valid_ns;
    logic        req_ready_ns, resp_valid_ns, resp_err_ns;
    logic [31:0] resp_rdata_ns;
    logic        mem_req_ns, mem_we_ns;
    logic        mem_ack_ns = 1'b0;
    logic [31:0] mem_rdata_ns = 32'h0;
    logic [31:0] mem_addr_ns, mem_wdata_ns;
    logic [3:0]  mem_be_ns;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    lsu_dm dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_dmtype(req_dmtype), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    lsu_dm #(.SPLIT_MISALIGNED(1'b0)) dut_ns (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_ns), .req_ready(req_ready_ns), .req_we(req_we),
        .req_dmtype(req_dmtype), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_ns), .resp_rdata(resp_rdata_ns), .resp_err(resp_err_ns),
        .mem_req(mem_req_ns), .mem_we(mem_we_ns), .mem_addr(mem_addr_ns), .mem_be(mem_be_ns),
        .mem_wdata(mem_wdata_ns), .mem_ack(mem_ack_ns), .mem_rdata(mem_rdata_ns)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic pop_and_compare(input string tag, input logic [31:0] rdata, input logic err);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s_sb observed=response expected=no_response", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_rdata"}, rdata, e.rdata);
            check({tag, "_err"}, {31'h0, err}, {31'h0, e.err});
        end
    endtask

    // One complete access on the default instance; nbeats = 0 means error path.
    task automatic access(input string tag, input logic we, input logic [2:0] ty,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int nbeats, input int waits,
                          input logic [31:0] a0, input logic [3:0] be0, input logic [31:0] wd0,
                          input logic [31:0] rd0,
                          input logic [31:0] a1, input logic [3:0] be1, input logic [31:0] wd1,
                          input logic [31:0] rd1,
                          input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        @(negedge clk);
        check({tag, "_ready"}, {31'h0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_dmtype = ty;
        req_addr   = addr;
        req_wdata  = wdata;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb.push_back(e);
        @(posedge clk);
        for (int b = 0; b < nbeats; b++) begin
            for (int w = 0; w <= waits; w++) begin
                @(negedge clk);
                req_valid = 1'b0;
                check({tag, "_mem_req"}, {31'h0, mem_req}, 32'd1);
                check({tag, "_busy"}, {31'h0, req_ready}, 32'd0);
                check({tag, "_mem_we"}, {31'h0, mem_we}, {31'h0, we});
                check({tag, "_mem_addr"}, mem_addr, (b == 0) ? a0 : a1);
                check({tag, "_mem_be"}, {28'h0, mem_be}, {28'h0, (b == 0) ? be0 : be1});
                if (we)
                    check({tag, "_mem_wdata"}, mem_wdata & lane_mask(mem_be),
                          ((b == 0) ? wd0 : wd1) & lane_mask((b == 0) ? be0 : be1));
                check({tag, "_early_resp"}, {31'h0, resp_valid}, 32'd0);
                mem_ack   = (w == waits);
                mem_rdata = (w == waits) ? ((b == 0) ? rd0 : rd1) : 32'hDEADBEEF;
                @(posedge clk);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check({tag, "_resp_valid"}, {31'h0, resp_valid}, 32'd1);
        check({tag, "_resp_noreq"}, {31'h0, mem_req}, 32'd0);
        if (resp_valid)
            pop_and_compare(tag, resp_rdata, resp_err);
        $display("txn %s we=%0b type=%0d addr=0x%08h rdata=0x%08h err=%0b",
                 tag, we, ty, addr, resp_rdata, resp_err);
        @(negedge clk);
        check({tag, "_resp_drop"}, {31'h0, resp_valid}, 32'd0);
        check({tag, "_ready_again"}, {31'h0, req_ready}, 32'd1);
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_valid_ns = 1'b0;
        req_we       = 1'b0;
        req_dmtype   = 3'b000;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        mem_ack      = 1'b0;
        mem_rdata    = 32'h0;

        repeat (2) @(negedge clk);
        check("rst_mem_req", {31'h0, mem_req}, 32'd0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'h0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_req_ready", {31'h0, req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", {31'h0, req_ready}, 32'd1);

        // Stray ack while idle must not start anything.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_ack_resp", {31'h0, resp_valid}, 32'd0);
        check("stray_ack_req", {31'h0, mem_req}, 32'd0);

        access("lw_aligned", 1'b0, 3'b000, 32'h100, 32'h0, 1, 0,
               32'h100, 4'b1111, 32'h0, 32'h8899AABB, 32'h0, 4'b0000, 32'h0, 32'h0,
               32'h8899AABB, 1'b0);
        access("lb_sext", 1'b0, 3'b011, 32'h103, 32'h0, 1, 0,
               32'h100, 4'b1000, 32'h0, 32'h80112233, 32'h0, 4'b0000, 32'h0, 32'h0,
               32'hFFFFFF80, 1'b0);
        access("lbu_zext", 1'b0, 3'b100, 32'h103, 32'h0, 1, 0,
               32'h100, 4'b1000, 32'h0, 32'h80112233, 32'h0, 4'b0000, 32'h0, 32'h0,
               32'h00000080, 1'b0);
        access("lh_off2", 1'b0, 3'b001, 32'h102, 32'h0, 1, 1,
               32'h100, 4'b1100, 32'h0, 32'h9ABC1234, 32'h0, 4'b0000, 32'h0, 32'h0,
               32'hFFFF9ABC, 1'b0);
        access("sw_aligned", 1'b1, 3'b000, 32'h10, 32'hCAFEF00D, 1, 0,
               32'h10, 4'b1111, 32'hCAFEF00D, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0,
               32'h0, 1'b0);
        access("sh_split", 1'b1, 3'b001, 32'h203, 32'h0000BEEF, 2, 0,
               32'h200, 4'b1000, 32'hEF000000, 32'h0, 32'h204, 4'b0001, 32'h000000BE, 32'h0,
               32'h0, 1'b0);
        access("lw_split_wait", 1'b0, 3'b000, 32'h1, 32'h0, 2, 2,
               32'h0, 4'b1110, 32'h0, 32'h44332211, 32'h4, 4'b0001, 32'h0, 32'h88776655,
               32'h55443322, 1'b0);
        access("lhu_wrap", 1'b0, 3'b010, 32'hFFFFFFFF, 32'h0, 2, 0,
               32'hFFFFFFFC, 4'b1000, 32'h0, 32'h12000000, 32'h0, 4'b0001, 32'h0, 32'h000000F0,
               32'h0000F012, 1'b0);
        access("st_type010_err", 1'b1, 3'b010, 32'h300, 32'h12345678, 0, 0,
               32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0,
               32'h0, 1'b1);
        access("ld_type101_err", 1'b0, 3'b101, 32'h300, 32'h0, 0, 0,
               32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 4'b0000, 32'h0, 32'h0,
               32'h0, 1'b1);

        // Misaligned word on the non-splitting instance.
        @(negedge clk);
        check("ns_ready", {31'h0, req_ready_ns}, 32'd1);
        req_valid_ns = 1'b1;
        req_we       = 1'b0;
        req_dmtype   = 3'b000;
        req_addr     = 32'h2;
        begin
            exp_t e;
            e.rdata = 32'h0;
            e.err   = 1'b1;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid_ns = 1'b0;
        check("ns_resp_valid", {31'h0, resp_valid_ns}, 32'd1);
        check("ns_mem_req", {31'h0, mem_req_ns}, 32'd0);
        if (resp_valid_ns)
            pop_and_compare("ns_lw_mis", resp_rdata_ns, resp_err_ns);
        $display("txn ns_lw_mis we=0 type=0 addr=0x00000002 rdata=0x%08h err=%0b",
                 resp_rdata_ns, resp_err_ns);
        @(negedge clk);
        check("ns_resp_drop", {31'h0, resp_valid_ns}, 32'd0);

        // Reset while beat 1 of a split load is waiting for its ack.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_dmtype = 3'b000;
        req_addr   = 32'h1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h44332211;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        check("rstmid_beat1_req", {31'h0, mem_req}, 32'd1);
        check("rstmid_beat1_addr", mem_addr, 32'h4);
        rst = 1'b1;
        #1;
        check("rstmid_mem_req", {31'h0, mem_req}, 32'd0);
        check("rstmid_ready", {31'h0, req_ready}, 32'd0);
        @(negedge clk);
        check("rstmid_no_resp", {31'h0, resp_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("rstmid_ready_after", {31'h0, req_ready}, 32'd1);
        @(negedge clk);
        check("rstmid_still_idle", {31'h0, resp_valid | mem_req}, 32'd0);
        $display("txn reset_mid_beat1 discarded");

        access("lw_after_reset", 1'b0, 3'b000, 32'h40, 32'h0, 1, 0,
               32'h40, 4'b1111, 32'h0, 32'h0BADF00D, 32'h0, 4'b0000, 32'h0, 32'h0,
               32'h0BADF00D, 1'b0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
